// File: rtl/pacman_pkg.sv
// Shared types and sizes for the pacman sprite/motion blocks.
// Contents: dir_t, ghost_t, cand_t (one candidate-list entry), FSM state type,
// coordinate/sprite widths and the rev_dir helper.
package pacman_pkg;

    localparam int unsigned COORD_W  = 9;
    localparam int unsigned SPRITE_W = 8;
    localparam int unsigned SPRITE_H = 8;

    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

    // Ghost index order is also the per-frame update order.
    typedef enum logic [1:0] {RED, BLUE, YELLOW, PINK} ghost_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } cand_t;

    typedef enum logic [2:0] {
        S_IDLE, S_TARGET, S_QUERY, S_WAIT, S_MOVE, S_NEXT
    } motion_state_t;

    function automatic dir_t rev_dir(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

endpackage

// File: rtl/ghost_target_sel.sv
// Combinational target and candidate-direction selection for one ghost.
// Ports:
//   ghost          which ghost is being stepped (selects the targeting rule)
//   pac_x, pac_y   pacman sprite position
//   x, y, cur_dir  current ghost position and heading
//   cand_c         4-entry ordered candidate list; duplicates/empty slots have valid=0
module ghost_target_sel
    import pacman_pkg::*;
#(
    parameter int unsigned LOOKAHEAD = 32,
    parameter int unsigned MAX_X     = 216,
    parameter int unsigned MAX_Y     = 280
) (
    input  ghost_t             ghost,
    input  logic [COORD_W-1:0] pac_x,
    input  logic [COORD_W-1:0] pac_y,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  dir_t               cur_dir,
    output cand_t [3:0]        cand_c
);

    localparam int unsigned EXT_W = COORD_W + 1;
    localparam int unsigned D_W   = COORD_W + 2;

    logic [EXT_W-1:0]      sum_x, sum_y, tgt_x, tgt_y;
    logic signed [D_W-1:0] dx, dy;
    logic [D_W-1:0]        adx, ady;
    logic                  x_major, sec_zero;
    dir_t                  dx_dir, dy_dir, pri, sec;
    cand_t [3:0]           raw;

    always_comb begin
        // Targets with lookahead saturate at the playfield limit.
        sum_x = EXT_W'(pac_x) + EXT_W'(LOOKAHEAD);
        sum_y = EXT_W'(pac_y) + EXT_W'(LOOKAHEAD);
        tgt_x = EXT_W'(pac_x);
        tgt_y = EXT_W'(pac_y);
        case (ghost)
            PINK:   tgt_x = (sum_x > EXT_W'(MAX_X)) ? EXT_W'(MAX_X) : sum_x;
            BLUE:   tgt_y = (sum_y > EXT_W'(MAX_Y)) ? EXT_W'(MAX_Y) : sum_y;
            YELLOW: begin
                tgt_x = '0;
                tgt_y = '0;
            end
            default: ;
        endcase

        dx  = $signed(D_W'(tgt_x)) - $signed(D_W'(x));
        dy  = $signed(D_W'(tgt_y)) - $signed(D_W'(y));
        adx = dx[D_W-1] ? D_W'(-dx) : D_W'(dx);
        ady = dy[D_W-1] ? D_W'(-dy) : D_W'(dy);

        // Ties favour the x axis.
        x_major  = (adx >= ady);
        dx_dir   = dx[D_W-1] ? LEFT : RIGHT;
        dy_dir   = dy[D_W-1] ? UP : DOWN;
        pri      = x_major ? dx_dir : dy_dir;
        sec      = x_major ? dy_dir : dx_dir;
        sec_zero = x_major ? (dy == '0) : (dx == '0);

        raw = '0;
        if (dx == '0 && dy == '0) begin
            raw[0] = '{valid: 1'b1, dir: cur_dir};
            raw[1] = '{valid: 1'b1, dir: rev_dir(cur_dir)};
        end else begin
            raw[0] = '{valid: 1'b1,      dir: pri};
            raw[1] = '{valid: !sec_zero, dir: sec};
            raw[2] = '{valid: 1'b1,      dir: cur_dir};
            raw[3] = '{valid: 1'b1,      dir: rev_dir(pri)};
        end

        // Drop any entry repeating a direction already offered earlier.
        cand_c = raw;
        for (int i = 1; i < 4; i++) begin
            for (int j = 0; j < i; j++) begin
                if (raw[j].valid && raw[j].dir == raw[i].dir)
                    cand_c[i].valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ghost_motion_ctrl.sv
// Steps the four ghost sprites toward their targets once per frame_tick,
// validating each candidate move against the maze-wall lookup (req/ack).
// Ports:
//   clk, rst                 clock, async active-high reset
//   frame_tick               vblank start pulse (ignored while busy)
//   pac_x, pac_y             pacman position, sampled per ghost when its target is chosen
//   wall_req/x/y             wall query out: candidate top-left, held until wall_ack
//   wall_ack, wall_hit       wall lookup response
//   x_*/y_*                  ghost positions (red, blue, yellow, pink)
//   busy                     frame update in progress
module ghost_motion_ctrl
    import pacman_pkg::*;
#(
    parameter int unsigned        SPEED     = 1,
    parameter int unsigned        MAX_X     = 216,
    parameter int unsigned        MAX_Y     = 280,
    parameter int unsigned        LOOKAHEAD = 32,
    parameter logic [COORD_W-1:0] RST_X_R   = 9'd104,
    parameter logic [COORD_W-1:0] RST_X_B   = 9'd88,
    parameter logic [COORD_W-1:0] RST_X_Y   = 9'd104,
    parameter logic [COORD_W-1:0] RST_X_P   = 9'd120,
    parameter logic [COORD_W-1:0] RST_Y_R   = 9'd112,
    parameter logic [COORD_W-1:0] RST_Y_B   = 9'd112,
    parameter logic [COORD_W-1:0] RST_Y_Y   = 9'd112,
    parameter logic [COORD_W-1:0] RST_Y_P   = 9'd112
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] pac_x,
    input  logic [COORD_W-1:0] pac_y,
    output logic               wall_req,
    output logic [COORD_W-1:0] wall_x,
    output logic [COORD_W-1:0] wall_y,
    input  logic               wall_ack,
    input  logic               wall_hit,
    output logic [COORD_W-1:0] x_red,
    output logic [COORD_W-1:0] y_red,
    output logic [COORD_W-1:0] x_blue,
    output logic [COORD_W-1:0] y_blue,
    output logic [COORD_W-1:0] x_yellow,
    output logic [COORD_W-1:0] y_yellow,
    output logic [COORD_W-1:0] x_pink,
    output logic [COORD_W-1:0] y_pink,
    output logic               busy
);

    localparam int unsigned        EXT_W = COORD_W + 1;
    localparam logic [COORD_W-1:0] STEP  = COORD_W'(SPEED);

    motion_state_t      state, state_d;
    logic [1:0]         g, g_d, ci, ci_d, sel, sel_d, pick;
    cand_t [3:0]        cand_q, cand_d, cand_c;
    logic               wall_req_d, busy_d, mv_en, found;
    logic [COORD_W-1:0] wall_x_d, wall_y_d, cur_x, cur_y;
    logic [COORD_W-1:0] pos_x [4];
    logic [COORD_W-1:0] pos_y [4];
    dir_t               dir_q [4];
    logic [COORD_W-1:0] step_x [4];
    logic [COORD_W-1:0] step_y [4];
    logic [3:0]         step_ok;

    assign cur_x = pos_x[g];
    assign cur_y = pos_y[g];

    ghost_target_sel #(
        .LOOKAHEAD (LOOKAHEAD),
        .MAX_X     (MAX_X),
        .MAX_Y     (MAX_Y)
    ) u_sel (
        .ghost   (ghost_t'(g)),
        .pac_x   (pac_x),
        .pac_y   (pac_y),
        .x       (cur_x),
        .y       (cur_y),
        .cur_dir (dir_q[g]),
        .cand_c  (cand_c)
    );

    // Candidate position per direction; moves leaving [0, MAX] are illegal.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            step_x[d] = cur_x;
            step_y[d] = cur_y;
        end
        step_y[UP]     = cur_y - STEP;
        step_ok[UP]    = (cur_y >= STEP);
        step_y[DOWN]   = cur_y + STEP;
        step_ok[DOWN]  = (EXT_W'(cur_y) + EXT_W'(STEP) <= EXT_W'(MAX_Y));
        step_x[LEFT]   = cur_x - STEP;
        step_ok[LEFT]  = (cur_x >= STEP);
        step_x[RIGHT]  = cur_x + STEP;
        step_ok[RIGHT] = (EXT_W'(cur_x) + EXT_W'(STEP) <= EXT_W'(MAX_X));
    end

    // First remaining candidate that is listed and legal, from index ci on.
    always_comb begin
        found = 1'b0;
        pick  = ci;
        for (int i = 0; i < 4; i++) begin
            if (!found && 2'(i) >= ci && cand_q[i].valid && step_ok[cand_q[i].dir]) begin
                found = 1'b1;
                pick  = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state;
        g_d        = g;
        ci_d       = ci;
        sel_d      = sel;
        cand_d     = cand_q;
        wall_req_d = wall_req;
        wall_x_d   = wall_x;
        wall_y_d   = wall_y;
        busy_d     = busy;
        mv_en      = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_tick) begin
                    g_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_TARGET;
                end
            end
            S_TARGET: begin
                cand_d  = cand_c;
                ci_d    = '0;
                state_d = S_QUERY;
            end
            S_QUERY: begin
                if (found) begin
                    wall_req_d = 1'b1;
                    wall_x_d   = step_x[cand_q[pick].dir];
                    wall_y_d   = step_y[cand_q[pick].dir];
                    sel_d      = pick;
                    state_d    = S_WAIT;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WAIT: begin
                if (wall_ack) begin
                    wall_req_d = 1'b0;
                    if (!wall_hit) begin
                        state_d = S_MOVE;
                    end else if (sel == 2'd3) begin
                        state_d = S_NEXT;
                    end else begin
                        ci_d    = sel + 2'd1;
                        state_d = S_QUERY;
                    end
                end
            end
            S_MOVE: begin
                mv_en   = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (g == 2'd3) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    g_d     = g + 2'd1;
                    state_d = S_TARGET;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers; a move commits the accepted candidate still held on wall_x/y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g        <= '0;
            ci       <= '0;
            sel      <= '0;
            cand_q   <= '0;
            wall_req <= 1'b0;
            wall_x   <= '0;
            wall_y   <= '0;
            busy     <= 1'b0;
            pos_x[0] <= RST_X_R;
            pos_x[1] <= RST_X_B;
            pos_x[2] <= RST_X_Y;
            pos_x[3] <= RST_X_P;
            pos_y[0] <= RST_Y_R;
            pos_y[1] <= RST_Y_B;
            pos_y[2] <= RST_Y_Y;
            pos_y[3] <= RST_Y_P;
            for (int i = 0; i < 4; i++) dir_q[i] <= LEFT;
        end else begin
            g        <= g_d;
            ci       <= ci_d;
            sel      <= sel_d;
            cand_q   <= cand_d;
            wall_req <= wall_req_d;
            wall_x   <= wall_x_d;
            wall_y   <= wall_y_d;
            busy     <= busy_d;
            if (mv_en) begin
                pos_x[g] <= wall_x;
                pos_y[g] <= wall_y;
                dir_q[g] <= cand_q[sel].dir;
            end
        end
    end

    assign x_red    = pos_x[RED];
    assign y_red    = pos_y[RED];
    assign x_blue   = pos_x[BLUE];
    assign y_blue   = pos_y[BLUE];
    assign x_yellow = pos_x[YELLOW];
    assign y_yellow = pos_y[YELLOW];
    assign x_pink   = pos_x[PINK];
    assign y_pink   = pos_y[PINK];

endmodule

// File: tb/tb_ghost_motion_ctrl.sv
// Directed bench for ghost_motion_ctrl with a behavioural wall-lookup responder.
// Yellow starts at x=0 and pink at x=200 so the edge and saturation cases are reachable.
module tb_ghost_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst, frame_tick, wall_ack, wall_hit, wall_req, busy;
    logic [8:0] pac_x, pac_y, wall_x, wall_y;
    logic [8:0] x_red, y_red, x_blue, y_blue, x_yellow, y_yellow, x_pink, y_pink;

    int n_vec = 0;
    int n_err = 0;

    // Responder controls and request log.
    int         ack_lat     = 1;
    int         hit_first_n = 0;
    bit         hit_all     = 1'b0;
    bit         chk_stable  = 1'b0;
    int         req_cnt     = 0;
    int         cyc_in_req  = 0;
    logic [8:0] hold_x, hold_y;
    logic [8:0] log_x [$];
    logic [8:0] log_y [$];

    always #5 clk = ~clk;

    ghost_motion_ctrl #(
        .RST_X_Y (9'd0),
        .RST_X_P (9'd200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .pac_x      (pac_x),
        .pac_y      (pac_y),
        .wall_req   (wall_req),
        .wall_x     (wall_x),
        .wall_y     (wall_y),
        .wall_ack   (wall_ack),
        .wall_hit   (wall_hit),
        .x_red      (x_red),
        .y_red      (y_red),
        .x_blue     (x_blue),
        .y_blue     (y_blue),
        .x_yellow   (x_yellow),
        .y_yellow   (y_yellow),
        .x_pink     (x_pink),
        .y_pink     (y_pink),
        .busy       (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag,
                             input int rx, input int ry, input int bx, input int by,
                             input int yx, input int yy, input int px, input int py);
        check({tag, "_x_red"},    int'(x_red),    rx);
        check({tag, "_y_red"},    int'(y_red),    ry);
        check({tag, "_x_blue"},   int'(x_blue),   bx);
        check({tag, "_y_blue"},   int'(y_blue),   by);
        check({tag, "_x_yellow"}, int'(x_yellow), yx);
        check({tag, "_y_yellow"}, int'(y_yellow), yy);
        check({tag, "_x_pink"},   int'(x_pink),   px);
        check({tag, "_y_pink"},   int'(y_pink),   py);
    endtask

    // Wall lookup model: acks on the ack_lat-th cycle of each request.
    always @(negedge clk) begin
        if (rst || !wall_req) begin
            if (!rst && cyc_in_req > 0 && !wall_ack)
                check("req_held_to_ack", int'(wall_req), 1);
            cyc_in_req = 0;
            wall_ack   = 1'b0;
            wall_hit   = 1'b0;
        end else begin
            if (cyc_in_req == 0) begin
                log_x.push_back(wall_x);
                log_y.push_back(wall_y);
                hold_x = wall_x;
                hold_y = wall_y;
                req_cnt++;
            end else if (chk_stable) begin
                check("wall_x_stable", int'(wall_x), int'(hold_x));
                check("wall_y_stable", int'(wall_y), int'(hold_y));
            end
            cyc_in_req++;
            if (cyc_in_req >= ack_lat) begin
                wall_ack = 1'b1;
                wall_hit = hit_all || (req_cnt <= hit_first_n);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        req_cnt = 0;
        log_x.delete();
        log_y.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One frame update; optional second tick mid-frame at loop cycle extra_at.
    task automatic run_frame(input string tag, input int extra_at);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check({tag, "_busy_rise"}, int'(busy), 1);
        for (int i = 1; i < 600 && busy; i++) begin
            frame_tick = (extra_at > 0 && i == extra_at);
            @(negedge clk);
        end
        frame_tick = 1'b0;
        check({tag, "_busy_fall"}, int'(busy), 0);
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        wall_ack   = 1'b0;
        wall_hit   = 1'b0;
        pac_x      = 9'd40;
        pac_y      = 9'd112;
        do_reset();

        // Reset values
        check("rst_wall_req", int'(wall_req), 0);
        check("rst_wall_x",   int'(wall_x),   0);
        check("rst_busy",     int'(busy),     0);
        check_pos("rst", 104, 112, 88, 112, 0, 112, 200, 112);

        // Free path: one step each toward its target
        run_frame("free", 0);
        check_pos("free", 103, 112, 87, 112, 0, 111, 199, 112);
        check("free_reqs", req_cnt, 4);

        // Blocked primary: red LEFT hit, falls through to RIGHT
        do_reset();
        hit_first_n = 1;
        run_frame("blk", 0);
        check_pos("blk", 105, 112, 87, 112, 0, 111, 199, 112);
        check("blk_reqs", req_cnt, 5);
        check("blk_req0_x", int'(log_x[0]), 103);
        check("blk_req1_x", int'(log_x[1]), 105);
        hit_first_n = 0;

        // All blocked: nobody moves; yellow's LEFT at x=0 never queried
        do_reset();
        hit_all = 1'b1;
        run_frame("allblk", 0);
        check_pos("allblk", 104, 112, 88, 112, 0, 112, 200, 112);
        check("allblk_reqs", req_cnt, 9);
        check("allblk_red_req1_x", int'(log_x[1]), 105);
        check("allblk_blue_req1_y", int'(log_y[3]), 113);
        check("allblk_yel_req0_y", int'(log_y[5]), 111);
        check("allblk_yel_req1_x", int'(log_x[6]), 0);
        check("allblk_yel_req1_y", int'(log_y[6]), 113);
        hit_all = 1'b0;

        // Slow ack with a stray tick while busy
        do_reset();
        ack_lat    = 5;
        chk_stable = 1'b1;
        run_frame("slow", 8);
        repeat (10) @(negedge clk);
        check("slow_busy_stays_low", int'(busy), 0);
        check_pos("slow", 103, 112, 87, 112, 0, 111, 199, 112);
        check("slow_reqs", req_cnt, 4);
        chk_stable = 1'b0;
        ack_lat    = 1;

        // Saturated pink target: x=216, so dy=20 beats dx=16 and pink goes DOWN
        do_reset();
        pac_x = 9'd200;
        pac_y = 9'd132;
        run_frame("sat", 0);
        check_pos("sat", 105, 112, 89, 112, 0, 111, 200, 113);

        // Async reset while waiting on an ack
        ack_lat = 1000;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 50 && !wall_req; i++) @(negedge clk);
        check("mid_req_up", int'(wall_req), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_wall_req", int'(wall_req), 0);
        check("mid_rst_busy",     int'(busy),     0);
        check("mid_rst_wall_x",   int'(wall_x),   0);
        check_pos("mid_rst", 104, 112, 88, 112, 0, 112, 200, 112);
        @(negedge clk);
        rst = 1'b0;
        ack_lat = 1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
